// File: rtl/rv_pkg.sv
// Shared hazard-control types: FSM state encoding and register-address width.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package rv_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hz_state_t;

  // A load in EX whose destination (never x0) is read by the instruction in ID.
  function automatic logic load_use(
    input logic                  memrd,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs1,
    input logic [REG_ADDR_W-1:0] rs2,
    input logic                  use_rs1,
    input logic                  use_rs2
  );
    logic hit1;
    logic hit2;
    hit1 = use_rs1 && (rs1 == rd);
    hit2 = use_rs2 && (rs2 == rd);
    return memrd && (rd != '0) && (hit1 || hit2);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// Latency: count visible the cycle after inc; clr wins over inc.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  // Count up on inc until all-ones; synchronous clear has priority.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != MAX)) begin
      q <= q + ONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use bubbles, branch flushes, data-memory wait freeze/timeout.
// Latency: control outputs combinational from state+inputs; state/counters update next edge.
// Backpressure: dmem wait freezes the front end; timeout parks in HALT until reset.
module hazard_ctrl
  import rv_pkg::*;
#(
  parameter int NBITS       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idex_memrd,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic [REG_ADDR_W-1:0] ifid_rs1,
  input  logic [REG_ADDR_W-1:0] ifid_rs2,
  input  logic                  ifid_use_rs1,
  input  logic                  ifid_use_rs2,
  input  logic                  branch_taken,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_en,
  output logic                  IFID_enable,
  output logic                  muxControl,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  stall,
  output logic                  mem_err,
  output logic [NBITS-1:0]      stall_cnt,
  output logic [NBITS-1:0]      flush_cnt
);

  // Wide enough to hold MEM_TIMEOUT itself, so the counter tops out before wrapping.
  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WC_ONE = WCW'(1);
  localparam logic [WCW-1:0] WC_MAX = WCW'(MEM_TIMEOUT);

  hz_state_t      state_q;
  hz_state_t      state_d;
  logic [WCW-1:0] wcnt_q;
  logic [WCW-1:0] wcnt_d;
  logic           lu;
  logic           mw;

  assign lu = load_use(idex_memrd, idex_rd, ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2);
  assign mw = dmem_req && !dmem_ready;

  // The error flag is simply "we are parked in HALT"; only reset leaves HALT.
  assign mem_err = (state_q == HALT);

  // Control outputs. MEM_WAIT without a pending wait resolves exactly like RUN,
  // and in MEM_WAIT the mw freeze outranks any branch, so both share one path.
  always_comb begin
    pc_en       = 1'b1;
    IFID_enable = 1'b1;
    muxControl  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    stall       = 1'b0;
    if (!rst) begin
      pc_en       = 1'b0;
      IFID_enable = 1'b0;
      muxControl  = 1'b1;
      stall       = 1'b1;
    end else if (state_q == HALT) begin
      pc_en       = 1'b0;
      IFID_enable = 1'b0;
      muxControl  = 1'b1;
      stall       = 1'b1;
    end else if (mw) begin
      // Full freeze: hold everything, no bubble, no flush.
      pc_en       = 1'b0;
      IFID_enable = 1'b0;
      stall       = 1'b1;
    end else if (branch_taken) begin
      // Squash the two wrong-path instructions; a coincident load-use is moot.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (lu) begin
      // One-cycle bubble: hold PC and IF/ID, inject a NOP into ID/EX.
      pc_en       = 1'b0;
      IFID_enable = 1'b0;
      muxControl  = 1'b1;
      stall       = 1'b1;
    end
  end

  // Next state and memory-wait counter.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      RUN: begin
        if (mw) begin
          state_d = MEM_WAIT;
          wcnt_d  = WC_ONE;
        end
      end
      MEM_WAIT: begin
        if (mw) begin
          if (wcnt_q == WC_MAX) begin
            state_d = HALT;
          end else begin
            wcnt_d = wcnt_q + WC_ONE;
          end
        end else begin
          state_d = RUN;
          wcnt_d  = '0;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  sat_counter #(.WIDTH(NBITS)) u_stall_cnt (
    .clk (clk),
    .clr (!rst),
    .inc (stall),
    .q   (stall_cnt)
  );

  sat_counter #(.WIDTH(NBITS)) u_flush_cnt (
    .clk (clk),
    .clr (!rst),
    .inc (idex_flush),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
// Counters run at 4 bits so saturation is exercised continuously.
module tb_hazard_ctrl;
  localparam int NB = 4;
  localparam int TO = 15;
  localparam int CMAX = (1 << NB) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          idex_memrd;
  logic [4:0]    idex_rd;
  logic [4:0]    ifid_rs1;
  logic [4:0]    ifid_rs2;
  logic          ifid_use_rs1;
  logic          ifid_use_rs2;
  logic          branch_taken;
  logic          dmem_req;
  logic          dmem_ready;
  logic          pc_en;
  logic          IFID_enable;
  logic          muxControl;
  logic          ifid_flush;
  logic          idex_flush;
  logic          stall;
  logic          mem_err;
  logic [NB-1:0] stall_cnt;
  logic [NB-1:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model: counts, consecutive-wait length, halted flag.
  int m_sc = 0;
  int m_fc = 0;
  int m_waits = 0;
  bit m_halted = 1'b0;

  hazard_ctrl #(.NBITS(NB), .MEM_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .idex_memrd   (idex_memrd),
    .idex_rd      (idex_rd),
    .ifid_rs1     (ifid_rs1),
    .ifid_rs2     (ifid_rs2),
    .ifid_use_rs1 (ifid_use_rs1),
    .ifid_use_rs2 (ifid_use_rs2),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_en        (pc_en),
    .IFID_enable  (IFID_enable),
    .muxControl   (muxControl),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .stall        (stall),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit memrd, input int rd, input int rs1, input int rs2,
                       input bit u1, input bit u2, input bit br, input bit req, input bit rdy);
    rst          = r;
    idex_memrd   = memrd;
    idex_rd      = 5'(rd);
    ifid_rs1     = 5'(rs1);
    ifid_rs2     = 5'(rs2);
    ifid_use_rs1 = u1;
    ifid_use_rs2 = u2;
    branch_taken = br;
    dmem_req     = req;
    dmem_ready   = rdy;
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Compare DUT against the model for the current cycle, then advance the model.
  task automatic model_check();
    bit lu;
    bit mw;
    bit e_pc, e_ifid, e_mux, e_ff, e_stall;
    lu = idex_memrd && (idex_rd != 0) &&
         ((ifid_use_rs1 && ifid_rs1 == idex_rd) || (ifid_use_rs2 && ifid_rs2 == idex_rd));
    mw = dmem_req && !dmem_ready;
    if (!rst || m_halted) begin
      e_pc = 0; e_ifid = 0; e_mux = 1; e_ff = 0; e_stall = 1;
    end else if (mw) begin
      e_pc = 0; e_ifid = 0; e_mux = 0; e_ff = 0; e_stall = 1;
    end else if (branch_taken) begin
      e_pc = 1; e_ifid = 1; e_mux = 0; e_ff = 1; e_stall = 0;
    end else if (lu) begin
      e_pc = 0; e_ifid = 0; e_mux = 1; e_ff = 0; e_stall = 1;
    end else begin
      e_pc = 1; e_ifid = 1; e_mux = 0; e_ff = 0; e_stall = 0;
    end
    chk("pc_en", 32'(pc_en), 32'(e_pc));
    chk("IFID_enable", 32'(IFID_enable), 32'(e_ifid));
    chk("muxControl", 32'(muxControl), 32'(e_mux));
    chk("ifid_flush", 32'(ifid_flush), 32'(e_ff));
    chk("idex_flush", 32'(idex_flush), 32'(e_ff));
    chk("stall", 32'(stall), 32'(e_stall));
    chk("mem_err", 32'(mem_err), 32'(m_halted));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_sc));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_fc));
    if (!rst) begin
      m_sc = 0; m_fc = 0; m_waits = 0; m_halted = 0;
    end else begin
      if (e_stall && m_sc < CMAX) m_sc++;
      if (e_ff && m_fc < CMAX) m_fc++;
      if (!m_halted) begin
        if (mw) begin
          m_waits++;
          if (m_waits > TO) m_halted = 1;
        end else begin
          m_waits = 0;
        end
      end
    end
  endtask

  // Sample at the falling edge (inputs are driven just after the rising edge).
  task automatic tick();
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); adv();
    idle();
  endtask

  initial begin
    int stuck;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    adv();

    // Reset behaviour.
    tick();
    chk("rst_pc_en", 32'(pc_en), 0);
    chk("rst_mux", 32'(muxControl), 1);
    chk("rst_stall", 32'(stall), 1);
    adv(); idle(); tick();
    chk("post_rst_pc_en", 32'(pc_en), 1);
    chk("post_rst_stall_cnt", 32'(stall_cnt), 0);
    chk("post_rst_mem_err", 32'(mem_err), 0);

    // Load-use bubble for exactly one cycle.
    adv(); drive(1, 1, 5, 5, 0, 1, 0, 0, 0, 0); tick();
    chk("lu_pc_en", 32'(pc_en), 0);
    chk("lu_ifid_en", 32'(IFID_enable), 0);
    chk("lu_mux", 32'(muxControl), 1);
    chk("lu_stall", 32'(stall), 1);
    adv(); idle(); tick();
    chk("lu_after_pc_en", 32'(pc_en), 1);
    chk("lu_after_stall_cnt", 32'(stall_cnt), 1);

    // Load into x0 is never a hazard.
    adv(); drive(1, 1, 0, 0, 0, 1, 0, 0, 0, 0); tick();
    chk("x0_stall", 32'(stall), 0);
    chk("x0_pc_en", 32'(pc_en), 1);

    // Branch beats load-use.
    adv(); do_reset();
    drive(1, 1, 5, 5, 0, 1, 0, 1, 0, 0); tick();
    chk("br_ifid_flush", 32'(ifid_flush), 1);
    chk("br_idex_flush", 32'(idex_flush), 1);
    chk("br_mux", 32'(muxControl), 0);
    chk("br_pc_en", 32'(pc_en), 1);
    adv(); idle(); tick();
    chk("br_flush_cnt", 32'(flush_cnt), 1);

    // Three memory-wait cycles, then ready.
    adv(); do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
      chk("mw_pc_en", 32'(pc_en), 0);
      chk("mw_stall", 32'(stall), 1);
      adv();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
    chk("mw_ready_pc_en", 32'(pc_en), 1);
    chk("mw_ready_stall", 32'(stall), 0);
    adv(); idle(); tick();
    chk("mw_stall_cnt", 32'(stall_cnt), 3);
    chk("mw_mem_err", 32'(mem_err), 0);

    // Timeout: 16 wait cycles, HALT from cycle 17 on.
    adv(); do_reset();
    for (int i = 1; i <= TO + 2; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
      if (i == TO + 1) chk("to_not_yet", 32'(mem_err), 0);
      if (i == TO + 2) chk("to_halt_mem_err", 32'(mem_err), 1);
      adv();
    end
    idle(); drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    chk("halt_mem_err_held", 32'(mem_err), 1);
    chk("halt_mux", 32'(muxControl), 1);
    chk("halt_branch_ignored", 32'(idex_flush), 0);
    adv(); do_reset(); tick();
    chk("halt_rst_mem_err", 32'(mem_err), 0);
    chk("halt_rst_pc_en", 32'(pc_en), 1);

    // Saturation: 20 stall cycles on a 4-bit counter.
    adv(); do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 3, 0, 3, 0, 1, 0, 0, 0); tick(); adv();
    end
    idle(); tick();
    chk("sat_stall_cnt", 32'(stall_cnt), 15);
    adv();

    // Randomized traffic against the model.
    stuck = 0;
    for (int c = 0; c < 4000; c++) begin
      bit r;
      bit req;
      bit rdy;
      r = ($urandom_range(0, 59) != 0);
      if (stuck > 0) begin
        req = 1; rdy = 0; stuck--;
      end else begin
        req = ($urandom_range(0, 3) == 0);
        rdy = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 99) == 0) stuck = 20;
      end
      drive(r, $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 4) == 0, req, rdy);
      tick(); adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
